pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V core front end. It holds the fetch PC, stretches reset for a configurable number of cycles so instruction memory sees a stable reset vector, and arbitrates prioritised redirect requests (e.g. trap, jump/branch). Redirects that arrive while fetch is stalled are buffered and applied when the stall releases. `pc_next` drives the synchronous instruction-memory read address; `pc` is the PC of the instruction being returned.

---
 rtl/pc_gen_if.sv | 53 +++++
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// -----------------------------------------------------------------------------
// pc_gen_if
//   Bundle of fetch-control signals between the core front end and pc_gen.
//
//   master : front-end control side. Drives stall and the redirect requests,
//            and observes the PC outputs.
//   slave  : pc_gen side. Consumes stall and the redirects, and drives the
//            PC and status outputs.
//
//   stall            : hold PC this cycle
//   redirect_valid   : per-channel redirect request (channel 0 highest)
//   redirect_target  : channel i target at [i*WIDTH +: WIDTH]
//   pc               : registered PC of the instruction being returned
//   pc_next          : value pc takes at the next edge (imem read address)
//   reset_active     : reset or reset-stretch still in progress
//   redirect_pending : a redirect captured during a stall is waiting
//   misaligned       : low alignment bits of pc are non-zero
// -----------------------------------------------------------------------------
interface pc_gen_if #(
  parameter int WIDTH        = 32,
  parameter int NUM_REDIRECT = 2
);
  logic                          stall;
  logic [NUM_REDIRECT-1:0]       redirect_valid;
  logic [NUM_REDIRECT*WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0]              pc;
  logic [WIDTH-1:0]              pc_next;
  logic                          reset_active;
  logic                          redirect_pending;
  logic                          misaligned;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_target,
    input  pc,
    input  pc_next,
    input  reset_active,
    input  redirect_pending,
    input  misaligned
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output pc,
    output pc_next,
    output reset_active,
    output redirect_pending,
    output misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Fetch program-counter generator. It holds the fetch PC and stretches reset
//   for RESET_HOLD cycles after rst falls, so instruction memory sees a stable
//   reset vector. It also arbitrates prioritised redirects, where channel 0 wins.
//   A redirect that arrives during a stall is buffered and applied when the
//   stall releases.
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous, active-high reset
//     bus : pc_gen_if.slave. The interface file lists each signal.
// -----------------------------------------------------------------------------
module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = {WIDTH{1'b0}},
  parameter int               RESET_HOLD   = 1,
  parameter int unsigned      INC          = 4,
  parameter int               NUM_REDIRECT = 2,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  // The hold counter must be able to store RESET_HOLD. It keeps at least one
  // bit so that RESET_HOLD = 0 still gives a legal vector.
  localparam int CNT_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             pend_d;
  logic [WIDTH-1:0] pend_tgt_q;
  logic [WIDTH-1:0] pend_tgt_d;

  logic             hold_s;
  logic             any_s;
  logic [WIDTH-1:0] sel_tgt_s;

  // Priority select: the scan runs from the highest index down, so the lowest
  // valid index is written last and wins.
  always_comb begin
    sel_tgt_s = {WIDTH{1'b0}};
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      sel_tgt_s = bus.redirect_valid[i] ? bus.redirect_target[i*WIDTH +: WIDTH]
                                        : sel_tgt_s;
    end
  end

  assign any_s  = |bus.redirect_valid;
  // Reset, or the stretch counter still running. No request is honoured here.
  assign hold_s = rst | (cnt_q != {CNT_W{1'b0}});

  // Next-state logic: the hold phase first, then the run-phase priority cases.
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (hold_s) begin
      // Requests are dropped during the hold phase, and pend stays clear.
      pc_d   = RESET_PC;
      pend_d = 1'b0;
      if (cnt_q != {CNT_W{1'b0}}) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (bus.stall && any_s) begin
      // The newest stalled request overwrites any older buffered one.
      pc_d       = pc_q;
      pend_d     = 1'b1;
      pend_tgt_d = sel_tgt_s;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (any_s) begin
      // A live redirect beats a buffered one, and the buffered one is dropped.
      pc_d   = sel_tgt_s;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else begin
      // This add wraps modulo 2^WIDTH.
      pc_d = pc_q + WIDTH'(INC);
    end
  end

  // State registers with asynchronous reset. A rising rst clears any buffered
  // redirect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      cnt_q      <= CNT_W'(RESET_HOLD);
      pend_q     <= 1'b0;
      pend_tgt_q <= {WIDTH{1'b0}};
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_next          = pc_d;
  assign bus.reset_active     = hold_s;
  assign bus.redirect_pending = pend_q;

  // misaligned depends only on registered pc. Targets are never masked; a bad
  // target is only reported here.
  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign bus.misaligned = |pc_q[ALIGN_BITS-1:0];
    end else begin : g_noalign
      assign bus.misaligned = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
//   Directed bench for pc_gen with RESET_PC = 0x1000 and RESET_HOLD = 2.
//   Hand-written sequences cover the reset stretch and the asynchronous
//   mid-operation reset. A vector table covers priority, buffering,
//   overwrite, wrap and misalignment.
// -----------------------------------------------------------------------------
module tb_pc_gen;
  localparam int          W    = 32;
  localparam int          NR   = 2;
  localparam logic [31:0] RPC  = 32'h0000_1000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pc_gen_if #(.WIDTH(W), .NUM_REDIRECT(NR)) bus_if ();

  pc_gen #(
    .WIDTH(W), .RESET_PC(RPC), .RESET_HOLD(2), .INC(4),
    .NUM_REDIRECT(NR), .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  rv;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] exp_pc;   // expected pc_next before the edge = pc after it
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] rv, input logic [31:0] t0, input logic [31:0] t1);
    bus_if.stall           = s;
    bus_if.redirect_valid  = rv;
    bus_if.redirect_target = {t1, t0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // {stall, rv, t0, t1, exp_pc, exp_pend, exp_mis}; the table starts at pc = 0x1008.
    vecs[0]  = '{1'b0, 2'b11, 32'h200, 32'h300, 32'h200, 1'b0, 1'b0}; // ch0 wins
    vecs[1]  = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h204, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 32'h0,   32'h80,  32'h204, 1'b1, 1'b0}; // buffer ch1
    vecs[3]  = '{1'b1, 2'b00, 32'h0,   32'h0,   32'h204, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 32'h0,   32'h0,   32'h204, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h80,  1'b0, 1'b0}; // apply pending
    vecs[6]  = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h84,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'b01, 32'h40,  32'h0,   32'h84,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'b10, 32'h0,   32'h50,  32'h84,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 32'h60,  32'h0,   32'h60,  1'b0, 1'b0}; // live beats pending
    vecs[10] = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h64,  1'b0, 1'b0}; // pending was cleared
    vecs[11] = '{1'b0, 2'b10, 32'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h0,   1'b0, 1'b0}; // wrap
    vecs[13] = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h4,   1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 32'h102, 32'h0,   32'h102, 1'b0, 1'b1}; // misaligned
    vecs[15] = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h106, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 2'b01, 32'h8,   32'h0,   32'h8,   1'b0, 1'b0};
    vecs[17] = '{1'b1, 2'b01, 32'h40,  32'h0,   32'h8,   1'b1, 1'b0};
    vecs[18] = '{1'b1, 2'b10, 32'h0,   32'h50,  32'h8,   1'b1, 1'b0}; // overwrite
    vecs[19] = '{1'b0, 2'b00, 32'h0,   32'h0,   32'h50,  1'b0, 1'b0};

    // ---- Reset stretch ----
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #2;
    check("rst_pc",      bus_if.pc,               RPC);
    check("rst_pc_next", bus_if.pc_next,          RPC);
    check("rst_ra",      32'(bus_if.reset_active), 32'd1);
    check("rst_pend",    32'(bus_if.redirect_pending), 32'd0);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("rel_ra",      32'(bus_if.reset_active), 32'd1);
    tick(); // E0
    check("e0_pc",       bus_if.pc,               RPC);
    check("e0_ra",       32'(bus_if.reset_active), 32'd1);
    tick(); // E1
    check("e1_pc",       bus_if.pc,               RPC);
    check("e1_ra",       32'(bus_if.reset_active), 32'd0);
    check("e1_pc_next",  bus_if.pc_next,          32'h1004);
    tick();
    check("e2_pc",       bus_if.pc,               32'h1004);
    tick();
    check("e3_pc",       bus_if.pc,               32'h1008);

    // ---- Vector table ----
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].t0, vecs[i].t1);
      #1;
      check($sformatf("v%0d_pc_next", i), bus_if.pc_next, vecs[i].exp_pc);
      tick();
      check($sformatf("v%0d_pc", i),   bus_if.pc, vecs[i].exp_pc);
      check($sformatf("v%0d_pend", i), 32'(bus_if.redirect_pending), 32'(vecs[i].exp_pend));
      check($sformatf("v%0d_mis", i),  32'(bus_if.misaligned),       32'(vecs[i].exp_mis));
    end

    // ---- Asynchronous reset while a redirect is pending ----
    drive(1'b1, 2'b01, 32'h90, 32'h0);
    tick();
    check("mid_pend_set", 32'(bus_if.redirect_pending), 32'd1);
    check("mid_pc_held",  bus_if.pc, 32'h50);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_pc",   bus_if.pc,               RPC);
    check("mid_rst_pend", 32'(bus_if.redirect_pending), 32'd0);
    check("mid_rst_ra",   32'(bus_if.reset_active), 32'd1);
    check("mid_rst_pcn",  bus_if.pc_next,          RPC);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'b01, 32'h500, 32'h0);   // ignored during the hold phase
    tick(); // E0
    check("hold_e0_pc",   bus_if.pc, RPC);
    check("hold_e0_pend", 32'(bus_if.redirect_pending), 32'd0);
    drive(1'b1, 2'b10, 32'h0, 32'h600);   // stall and redirect are both dropped
    tick(); // E1
    check("hold_e1_pc",   bus_if.pc, RPC);
    check("hold_e1_pend", 32'(bus_if.redirect_pending), 32'd0);
    check("hold_e1_ra",   32'(bus_if.reset_active), 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    check("post_hold_pc", bus_if.pc, 32'h1004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
